spwm_gen: RTL and testbench



---
 rtl/spwm_gen.sv | 159 +++++++++++++++
 tb/tb_spwm_gen.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spwm_gen.sv
// spwm_gen - single-phase sinusoidal-PWM modulator stage.
//
// Compares a 12-bit modulating reference against an internal symmetric
// triangle carrier (0..CARRIER_MAX..1, period 2*CARRIER_MAX clocks) and
// drives a complementary high-side/low-side gate pair.
//
// Parameters:
//   CARRIER_MAX  triangle peak value, 2..4095
//   DEADTIME     dead-time length in clocks, 1..255 (dead-time build only)
//
// Ports:
//   CLK   system clock
//   RST   synchronous active-high reset
//   PWM   12-bit unsigned reference sample, captured only at the carrier valley
//   PH    high-side gate drive, active-high, registered
//   PL    low-side gate drive, active-high, registered
//   SYNC  one-cycle pulse aligned with the carrier valley (reference reload)
//
// Configuration macro:
//   SPWM_GEN_DEADTIME_EN  when defined, a dead-time output stage is built;
//                         otherwise PH = raw and PL = ~raw, one clock late.

module spwm_gen #(
  parameter int CARRIER_MAX = 4095,
  parameter int DEADTIME    = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [11:0] PWM,
  output logic        PH,
  output logic        PL,
  output logic        SYNC
);

  localparam logic [11:0] CMAX = 12'(CARRIER_MAX);

  // Reject parameter values outside the range the counters are sized for.
  if (CARRIER_MAX < 2 || CARRIER_MAX > 4095 || DEADTIME < 1 || DEADTIME > 255) begin : g_param_check
    $error("spwm_gen: CARRIER_MAX or DEADTIME out of range");
  end

  // START is the single cycle after reset in which the carrier is held at 0
  // so that the first valley (and SYNC) follows release immediately.
  typedef enum logic [1:0] {
    START,
    UP,
    DOWN
  } dir_t;

  dir_t        dir;
  dir_t        dir_next;
  logic [11:0] carrier;
  logic [11:0] carrier_next;
  logic [11:0] shadow;
  logic        raw;

  // Carrier, direction, valley pulse and reference shadow register.
  // SYNC and the shadow reload are keyed off the next carrier value so they
  // line up with the cycle in which the carrier actually sits at 0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      dir     <= START;
      carrier <= '0;
      shadow  <= '0;
      SYNC    <= 1'b0;
    end else begin
      dir     <= dir_next;
      carrier <= carrier_next;
      SYNC    <= (carrier_next == 12'd0);
      if (carrier_next == 12'd0) begin
        shadow <= PWM;
      end
    end
  end

  // Next carrier value and direction. The direction turns when the count
  // reaches the peak or the valley, so each endpoint appears once per period.
  always_comb begin
    dir_next     = dir;
    carrier_next = carrier;
    case (dir)
      START: begin
        carrier_next = 12'd0;
        dir_next     = UP;
      end
      UP: begin
        carrier_next = carrier + 12'd1;
        if (carrier + 12'd1 == CMAX) begin
          dir_next = DOWN;
        end
      end
      DOWN: begin
        carrier_next = carrier - 12'd1;
        if (carrier == 12'd1) begin
          dir_next = UP;
        end
      end
      default: begin
        carrier_next = 12'd0;
        dir_next     = START;
      end
    endcase
  end

  // A reference at or above the peak would otherwise drop out for the one
  // cycle the carrier equals it; forcing raw gives a true 100% duty.
  assign raw = (shadow >= CMAX) || (shadow > carrier);

`ifdef SPWM_GEN_DEADTIME_EN

  localparam logic [7:0] DT = 8'(DEADTIME);

  logic       raw_q;
  logic [7:0] dt_count;

  // Dead-time output stage. Every raw edge blanks both gates and (re)loads
  // the counter; the side selected by raw asserts on the clock the counter
  // would reach zero, giving exactly DEADTIME blanked cycles after the last
  // edge. The deasserting side therefore still drops one clock after raw.
  always_ff @(posedge CLK) begin
    if (RST) begin
      raw_q    <= 1'b0;
      dt_count <= '0;
      PH       <= 1'b0;
      PL       <= 1'b0;
    end else begin
      raw_q <= raw;
      if (raw != raw_q) begin
        dt_count <= DT;
        PH       <= 1'b0;
        PL       <= 1'b0;
      end else if (dt_count > 8'd1) begin
        dt_count <= dt_count - 8'd1;
        PH       <= 1'b0;
        PL       <= 1'b0;
      end else begin
        dt_count <= '0;
        PH       <= raw;
        PL       <= ~raw;
      end
    end
  end

`else

  // Plain complementary output stage, one clock behind raw.
  always_ff @(posedge CLK) begin
    if (RST) begin
      PH <= 1'b0;
      PL <= 1'b0;
    end else begin
      PH <= raw;
      PL <= ~raw;
    end
  end

`endif

endmodule

// File: tb/tb_spwm_gen.sv
// tb_spwm_gen - self-checking bench for spwm_gen.
//
// The expected outputs come from a reference model that describes the
// modulator in terms of elapsed time: the carrier is a function of the
// number of cycles since release, the shadow is whatever PWM held at each
// valley, and (with SPWM_GEN_DEADTIME_EN) a gate may assert only once
// DEADTIME cycles have passed since the most recent edge of the compare.
// Per-period high/low counts are also checked against closed-form duty
// figures.

module tb_spwm_gen;

  localparam int M = 16;
  localparam int D = 3;

  logic        CLK;
  logic        RST;
  logic [11:0] PWM;
  logic        PH;
  logic        PL;
  logic        SYNC;

  int nAssert = 0;
  int nFail   = 0;

  bit started    = 1'b0;
  int phase      = 0;
  int shadowM    = 0;
  bit rawPrev    = 1'b0;
  int cyc        = 0;
  int lastChange = -1000;
  bit expPh      = 1'b0;
  bit expPl      = 1'b0;
  bit expSync    = 1'b0;

  spwm_gen #(
    .CARRIER_MAX(M),
    .DEADTIME   (D)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .PWM (PWM),
    .PH  (PH),
    .PL  (PL),
    .SYNC(SYNC)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Triangle value reached n cycles after the first valley.
  function automatic int carrierAt(input int n);
    int p;
    p = n % (2 * M);
    return (p <= M) ? p : 2 * M - p;
  endfunction

  function automatic bit rawOf(input int sh, input int c);
    return (sh >= M) || (sh > c);
  endfunction

  // High/low gate cycles per steady-state period for a constant reference.
  function automatic int highCycles(input int r);
    int h;
    if (r == 0) return 0;
    if (r >= M) return 2 * M;
    h = 2 * r - 1;
`ifdef SPWM_GEN_DEADTIME_EN
    h = h - D;
    if (h < 0) h = 0;
`endif
    return h;
  endfunction

  function automatic int lowCycles(input int r);
    int l;
    if (r == 0) return 2 * M;
    if (r >= M) return 0;
    l = 2 * M - (2 * r - 1);
`ifdef SPWM_GEN_DEADTIME_EN
    l = l - D;
    if (l < 0) l = 0;
`endif
    return l;
  endfunction

  task automatic checkOutput(input string tag);
    nAssert++;
    assert (SYNC === expSync) else begin
      nFail++;
      $error("[TB] FAIL %s sync: observed %b expected %b", tag, SYNC, expSync);
    end
    nAssert++;
    assert (PH === expPh) else begin
      nFail++;
      $error("[TB] FAIL %s ph: observed %b expected %b (cyc %0d)", tag, PH, expPh, cyc);
    end
    nAssert++;
    assert (PL === expPl) else begin
      nFail++;
      $error("[TB] FAIL %s pl: observed %b expected %b (cyc %0d)", tag, PL, expPl, cyc);
    end
    nAssert++;
    assert ((PH & PL) === 1'b0) else begin
      nFail++;
      $error("[TB] FAIL %s overlap: observed ph=%b pl=%b expected never both 1", tag, PH, PL);
    end
  endtask

  // Drive one cycle, advance the model across the clock edge, then check.
  task automatic applyStimulus(input bit r, input int p, input string tag);
    bit rawNow;
    bit settled;
    rawNow = rawOf(shadowM, started ? carrierAt(phase) : 0);
    RST = r;
    PWM = 12'(p);
    @(posedge CLK);
    if (r) begin
      started    = 1'b0;
      shadowM    = 0;
      rawPrev    = 1'b0;
      cyc        = 0;
      lastChange = -1000;
      expPh      = 1'b0;
      expPl      = 1'b0;
      expSync    = 1'b0;
    end else begin
      if (rawNow != rawPrev) lastChange = cyc;
`ifdef SPWM_GEN_DEADTIME_EN
      settled = (cyc - lastChange) >= D;
`else
      settled = 1'b1;
`endif
      expPh   = rawNow && settled;
      expPl   = !rawNow && settled;
      rawPrev = rawNow;
      cyc++;
      if (!started) begin
        started = 1'b1;
        phase   = 0;
      end else begin
        phase++;
      end
      expSync = (carrierAt(phase) == 0);
      if (expSync) shadowM = p;
    end
    #1;
    checkOutput(tag);
  endtask

  task automatic checkDuty(input int r, input string tag);
    int hi;
    int lo;
    hi = 0;
    lo = 0;
    repeat (80) applyStimulus(1'b0, r, tag);
    repeat (2 * M) begin
      applyStimulus(1'b0, r, tag);
      hi += int'(PH);
      lo += int'(PL);
    end
    nAssert++;
    assert (hi == highCycles(r)) else begin
      nFail++;
      $error("[TB] FAIL %s high-count: observed %0d expected %0d", tag, hi, highCycles(r));
    end
    nAssert++;
    assert (lo == lowCycles(r)) else begin
      nFail++;
      $error("[TB] FAIL %s low-count: observed %0d expected %0d", tag, lo, lowCycles(r));
    end
  endtask

  task automatic waitFor(input bit wantPh, input bit useSync, input int p,
                         input int limit, input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < limit && !found; i++) begin
      applyStimulus(1'b0, p, tag);
      if (useSync ? (SYNC === 1'b1) : (PH === wantPh)) found = 1'b1;
    end
    nAssert++;
    assert (found === 1'b1) else begin
      nFail++;
      $error("[TB] FAIL %s wait: observed timeout after %0d cycles expected event", tag, limit);
    end
  endtask

  initial begin
    int hi;
    int pv;
    RST = 1'b1;
    PWM = '0;

    // Reset held for three cycles, then release into duty measurements.
    repeat (3) applyStimulus(1'b1, int'($urandom_range(0, 4095)), "reset");
    applyStimulus(1'b0, 5, "release");
    checkDuty(5, "duty5");
    checkDuty(0, "duty0");
    checkDuty(4095, "dutyfull");
    checkDuty(M, "dutypeak");
    checkDuty(8, "duty8");
    checkDuty(10, "duty10");

    // Reference changes mid-period only take effect at the next valley.
    repeat (70) applyStimulus(1'b0, 5, "shadow-pre");
    waitFor(1'b0, 1'b1, 5, 40, "shadow-sync");
    hi = 0;
    for (int i = 0; i < 2 * M; i++) begin
      applyStimulus(1'b0, (i < 8) ? 5 : 10, "shadow-cur");
      hi += int'(PH);
    end
    nAssert++;
    assert (hi == highCycles(5)) else begin
      nFail++;
      $error("[TB] FAIL shadow-cur high-count: observed %0d expected %0d", hi, highCycles(5));
    end
    hi = 0;
    repeat (2 * M) begin
      applyStimulus(1'b0, 10, "shadow-next");
      hi += int'(PH);
    end
    nAssert++;
    assert (hi == highCycles(10)) else begin
      nFail++;
      $error("[TB] FAIL shadow-next high-count: observed %0d expected %0d", hi, highCycles(10));
    end

    // Reference of 1 makes raw pulse for a single cycle at each valley.
    repeat (100) applyStimulus(1'b0, 1, "restart");

    // Randomised references, biased towards small values near the valley.
    for (int i = 0; i < 400; i++) begin
      pv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20))
                                       : int'($urandom_range(0, 4095));
      applyStimulus(1'b0, pv, "random");
    end

    // Reset right after the high side drops (dead time running).
    repeat (40) applyStimulus(1'b0, 8, "midrst-pre");
    waitFor(1'b1, 1'b0, 8, 80, "midrst-high");
    waitFor(1'b0, 1'b0, 8, 40, "midrst-fall");
    repeat (2) applyStimulus(1'b1, 8, "midrst-reset");
    repeat (70) applyStimulus(1'b0, int'($urandom_range(0, 4095)), "midrst-after");
    checkDuty(3, "duty3");

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
